multi_channel_producer: RTL and testbench

Parametrised traffic generator driving NUM_CH independent request channels into the downstream pipeline under test. Each channel emits a stall-respecting stream of incrementing addresses tagged with channel-stamped IDs. The block also issues flush pulses per channel, from a one-shot auto timer or a software request. A flush that targets the channel's own ID stream rewinds its sequence so the flushed ID is replayed. Flushes are never gated by stall.

---
 rtl/multi_channel_producer.sv | 113 +++++++++++
 tb/tb_multi_channel_producer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_producer.sv
// Multi-channel request generator: per-channel incrementing address/ID streams with
// stall hold, one-shot auto flush, software flush and ID-replay rewind on own-tag flushes.
module multi_channel_producer #(
    parameter int NUM_CH                   = 2,
    parameter int ADDRESS_WIDTH            = 32,
    parameter int ID_WIDTH                 = 8,
    parameter int ADDR_STRIDE              = 4,
    parameter int FLUSH_DELAY              = 45,
    parameter logic [7:0] AUTO_FLUSH_MASK  = 8'h01,
    parameter logic [ID_WIDTH-1:0] AUTO_FLUSH_ID = ID_WIDTH'(8'h19)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CH-1:0]                 ch_enable,
    input  logic [NUM_CH-1:0]                 in_stall,
    output logic [NUM_CH*ADDRESS_WIDTH-1:0]   out_address,
    output logic [NUM_CH*ID_WIDTH-1:0]        out_id,
    output logic [NUM_CH-1:0]                 out_valid,
    input  logic [NUM_CH-1:0]                 sw_flush_req,
    input  logic [NUM_CH*ID_WIDTH-1:0]        sw_flush_id,
    output logic [NUM_CH-1:0]                 flush,
    output logic [NUM_CH*ID_WIDTH-1:0]        flush_id
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int IW = ID_WIDTH;
    localparam int SW = ID_WIDTH / 2;
    localparam int TW = (FLUSH_DELAY > 1) ? $clog2(FLUSH_DELAY + 1) : 1;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [SW-1:0] TAG = SW'(c + 1);

        logic [SW-1:0] r_seq;
        logic [AW-1:0] r_addr;
        logic [IW-1:0] r_id;
        logic          r_valid;
        logic [TW-1:0] r_timer;
        logic          r_auto_done;
        logic          r_auto_pending;
        logic          r_flush;
        logic [IW-1:0] r_flush_id;

        logic          w_flush_nxt;
        logic [IW-1:0] w_flush_id_nxt;
        logic          w_rewind;
        logic          w_auto_fire;
        logic [SW-1:0] w_seq_inc;

        // Software request wins; a pending auto flush waits for the next free edge.
        always_comb begin
            w_flush_nxt    = 1'b0;
            w_flush_id_nxt = '0;
            if (sw_flush_req[c]) begin
                w_flush_nxt    = 1'b1;
                w_flush_id_nxt = sw_flush_id[c*IW +: IW];
            end else if (r_auto_pending) begin
                w_flush_nxt    = 1'b1;
                w_flush_id_nxt = AUTO_FLUSH_ID;
            end
        end

        assign w_rewind    = w_flush_nxt && (w_flush_id_nxt[IW-1:SW] == TAG);
        assign w_auto_fire = (r_timer == '0) && !r_auto_done && AUTO_FLUSH_MASK[c];
        assign w_seq_inc   = r_seq + SW'(1);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_timer        <= TW'(FLUSH_DELAY);
                r_auto_done    <= 1'b0;
                r_auto_pending <= 1'b0;
                r_flush        <= 1'b0;
                r_flush_id     <= '0;
            end else begin
                if (r_timer != '0)
                    r_timer <= r_timer - TW'(1);
                if (w_auto_fire) begin
                    r_auto_pending <= 1'b1;
                    r_auto_done    <= 1'b1;
                end else if (!sw_flush_req[c] && r_auto_pending) begin
                    r_auto_pending <= 1'b0;
                end
                r_flush    <= w_flush_nxt;
                r_flush_id <= w_flush_id_nxt;
            end
        end

        // Rewind to SEQ-1 so the next advance replays the flushed ID.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_seq   <= '0;
                r_addr  <= '0;
                r_id    <= '0;
                r_valid <= 1'b0;
            end else if (w_rewind) begin
                r_seq <= w_flush_id_nxt[SW-1:0] - SW'(1);
                if (!in_stall[c])
                    r_valid <= 1'b0;
            end else if (!in_stall[c]) begin
                r_seq   <= w_seq_inc;
                r_addr  <= r_addr + AW'(ADDR_STRIDE);
                r_id    <= {TAG, w_seq_inc};
                r_valid <= ch_enable[c];
            end
        end

        assign out_address[c*AW +: AW] = r_addr;
        assign out_id[c*IW +: IW]      = r_id;
        assign out_valid[c]            = r_valid;
        assign flush[c]                = r_flush;
        assign flush_id[c*IW +: IW]    = r_flush_id;
    end

endmodule

// File: tb/tb_multi_channel_producer.sv
// Directed bench for multi_channel_producer at default parameters: vector table for
// streaming/stall/enable, hand sequences for auto/sw flush, collision, wrap and reset.
module tb_multi_channel_producer;

    logic        clk;
    logic        reset;
    logic [1:0]  ch_enable;
    logic [1:0]  in_stall;
    logic [63:0] out_address;
    logic [15:0] out_id;
    logic [1:0]  out_valid;
    logic [1:0]  sw_flush_req;
    logic [15:0] sw_flush_id;
    logic [1:0]  flush;
    logic [15:0] flush_id;

    int n_cmp;
    int n_err;

    multi_channel_producer dut (
        .clk          (clk),
        .reset        (reset),
        .ch_enable    (ch_enable),
        .in_stall     (in_stall),
        .out_address  (out_address),
        .out_id       (out_id),
        .out_valid    (out_valid),
        .sw_flush_req (sw_flush_req),
        .sw_flush_id  (sw_flush_id),
        .flush        (flush),
        .flush_id     (flush_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        ch_enable    = 2'b11;
        in_stall     = 2'b00;
        sw_flush_req = 2'b00;
        sw_flush_id  = '0;
        #3;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic        stall0;
        logic        en1;
        logic [7:0]  id0;
        logic [31:0] a0;
        logic        v0;
        logic [7:0]  id1;
        logic [31:0] a1;
        logic        v1;
    } vec_t;

    vec_t tbl[10];
    int   pulses0;
    int   pulses1;

    initial begin
        n_cmp = 0;
        n_err = 0;

        tbl[0] = '{1'b0, 1'b1, 8'h11, 32'd4,  1'b1, 8'h21, 32'd4,  1'b1};
        tbl[1] = '{1'b0, 1'b1, 8'h12, 32'd8,  1'b1, 8'h22, 32'd8,  1'b1};
        tbl[2] = '{1'b1, 1'b1, 8'h12, 32'd8,  1'b1, 8'h23, 32'd12, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 8'h12, 32'd8,  1'b1, 8'h24, 32'd16, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 8'h12, 32'd8,  1'b1, 8'h25, 32'd20, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 8'h13, 32'd12, 1'b1, 8'h26, 32'd24, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 8'h14, 32'd16, 1'b1, 8'h27, 32'd28, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 8'h15, 32'd20, 1'b1, 8'h28, 32'd32, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 8'h16, 32'd24, 1'b1, 8'h29, 32'd36, 1'b1};
        tbl[9] = '{1'b0, 1'b1, 8'h17, 32'd28, 1'b1, 8'h2A, 32'd40, 1'b1};

        // ---- reset state
        reset        = 1'b1;
        ch_enable    = 2'b11;
        in_stall     = 2'b00;
        sw_flush_req = 2'b00;
        sw_flush_id  = '0;
        #3;
        chk("rst_addr",  32'(|out_address), 32'd0);
        chk("rst_id",    32'(out_id), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_fid",   32'(flush_id), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ---- streaming, stall on ch0, enable gap on ch1
        for (int i = 0; i < 10; i++) begin
            in_stall     = {1'b0, tbl[i].stall0};
            ch_enable    = {tbl[i].en1, 1'b1};
            step();
            chk($sformatf("tbl%0d_id0", i), 32'(out_id[7:0]), 32'(tbl[i].id0));
            chk($sformatf("tbl%0d_a0", i),  out_address[31:0], tbl[i].a0);
            chk($sformatf("tbl%0d_v0", i),  32'(out_valid[0]), 32'(tbl[i].v0));
            chk($sformatf("tbl%0d_id1", i), 32'(out_id[15:8]), 32'(tbl[i].id1));
            chk($sformatf("tbl%0d_a1", i),  out_address[63:32], tbl[i].a1);
            chk($sformatf("tbl%0d_v1", i),  32'(out_valid[1]), 32'(tbl[i].v1));
            chk($sformatf("tbl%0d_fl", i),  32'(flush), 32'd0);
        end

        // ---- auto flush on ch0 while stalled throughout
        do_reset();
        in_stall = 2'b01;
        pulses0 = 0;
        pulses1 = 0;
        for (int k = 1; k <= 46; k++) begin
            step();
            pulses0 += int'(flush[0]);
            pulses1 += int'(flush[1]);
        end
        chk("auto_early", 32'(pulses0), 32'd0);
        step();
        chk("auto_pulse", 32'(flush[0]), 32'd1);
        chk("auto_id",    32'(flush_id[7:0]), 32'h19);
        chk("auto_hold_id", 32'(out_id[7:0]), 32'd0);
        chk("auto_hold_v",  32'(out_valid[0]), 32'd0);
        chk("auto_ch1_id",  32'(out_id[15:8]), 32'h2F);
        pulses1 += int'(flush[1]);
        pulses0 = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            pulses0 += int'(flush[0]);
            pulses1 += int'(flush[1]);
        end
        chk("auto_once", 32'(pulses0), 32'd0);
        chk("auto_ch1_none", 32'(pulses1), 32'd0);
        in_stall = 2'b00;
        step();
        chk("auto_replay_id", 32'(out_id[7:0]), 32'h19);
        chk("auto_replay_a",  out_address[31:0], 32'd4);
        chk("auto_replay_v",  32'(out_valid[0]), 32'd1);
        step();
        chk("auto_next_id", 32'(out_id[7:0]), 32'h1A);
        chk("auto_next_a",  out_address[31:0], 32'd8);

        // ---- software flush on ch1 with own tag, then held request with foreign tag
        do_reset();
        for (int k = 1; k <= 7; k++) step();
        chk("sw_pre_id", 32'(out_id[15:8]), 32'h27);
        sw_flush_req = 2'b10;
        sw_flush_id  = 16'h2300;
        step();
        sw_flush_req = 2'b00;
        sw_flush_id  = '0;
        chk("sw_pulse",    32'(flush[1]), 32'd1);
        chk("sw_fid",      32'(flush_id[15:8]), 32'h23);
        chk("sw_bubble_v", 32'(out_valid[1]), 32'd0);
        chk("sw_bubble_a", out_address[63:32], 32'd28);
        chk("sw_ch0_id",   32'(out_id[7:0]), 32'h18);
        step();
        chk("sw_clear",    32'(flush), 32'd0);
        chk("sw_fid_zero", 32'(flush_id), 32'd0);
        chk("sw_replay",   32'(out_id[15:8]), 32'h23);
        chk("sw_replay_a", out_address[63:32], 32'd32);
        chk("sw_replay_v", 32'(out_valid[1]), 32'd1);
        step();
        chk("sw_next", 32'(out_id[15:8]), 32'h24);
        sw_flush_req = 2'b10;
        sw_flush_id  = 16'h4500;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("hold%0d_pulse", k), 32'(flush[1]), 32'd1);
            chk($sformatf("hold%0d_fid", k),   32'(flush_id[15:8]), 32'h45);
            chk($sformatf("hold%0d_id", k),    32'(out_id[15:8]), 32'h25 + 32'(k));
            chk($sformatf("hold%0d_v", k),     32'(out_valid[1]), 32'd1);
        end
        sw_flush_req = 2'b00;
        sw_flush_id  = '0;
        step();
        chk("hold_end", 32'(flush[1]), 32'd0);

        // ---- sw (foreign tag) collides with auto flush on ch0
        do_reset();
        pulses0 = 0;
        for (int k = 1; k <= 46; k++) begin
            step();
            pulses0 += int'(flush[0]);
        end
        chk("col_early", 32'(pulses0), 32'd0);
        sw_flush_req = 2'b01;
        sw_flush_id  = 16'h0035;
        step();
        sw_flush_req = 2'b00;
        sw_flush_id  = '0;
        chk("col_sw_pulse", 32'(flush[0]), 32'd1);
        chk("col_sw_id",    32'(flush_id[7:0]), 32'h35);
        chk("col_norew_id", 32'(out_id[7:0]), 32'h1F);
        chk("col_norew_v",  32'(out_valid[0]), 32'd1);
        step();
        chk("col_auto_pulse", 32'(flush[0]), 32'd1);
        chk("col_auto_id",    32'(flush_id[7:0]), 32'h19);
        chk("col_bubble_v",   32'(out_valid[0]), 32'd0);
        chk("col_bubble_a",   out_address[31:0], 32'd188);
        step();
        chk("col_done",   32'(flush[0]), 32'd0);
        chk("col_replay", 32'(out_id[7:0]), 32'h19);
        chk("col_replay_a", out_address[31:0], 32'd192);

        // ---- SEQ wrap, then async reset mid-stream and re-armed auto flush
        do_reset();
        for (int k = 1; k <= 15; k++) step();
        chk("wrap_top",   32'(out_id[7:0]), 32'h1F);
        chk("wrap_top_a", out_address[31:0], 32'd60);
        step();
        chk("wrap_zero",   32'(out_id[7:0]), 32'h10);
        chk("wrap_zero_a", out_address[31:0], 32'd64);
        chk("wrap_ch1",    32'(out_id[15:8]), 32'h20);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_addr",  32'(|out_address), 32'd0);
        chk("mid_rst_id",    32'(out_id), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("restart_id", 32'(out_id[7:0]), 32'h11);
        chk("restart_a",  out_address[31:0], 32'd4);
        pulses0 = 0;
        for (int k = 2; k <= 46; k++) begin
            step();
            pulses0 += int'(flush[0]);
        end
        chk("rearm_early", 32'(pulses0), 32'd0);
        step();
        chk("rearm_pulse", 32'(flush[0]), 32'd1);
        chk("rearm_id",    32'(flush_id[7:0]), 32'h19);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
